// File: rtl/vga_pkg.sv
// vga_pkg: 640x480 timing constants, the TinyVGA PMOD bit map and the receiver state type.
package vga_pkg;
    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FRONT  = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BACK   = 48;
    localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FRONT  = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BACK   = 33;
    localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

    // PMOD bus order {hsync,B0,G0,R0,vsync,B1,G1,R1}
    localparam int HS_BIT = 7;
    localparam int B0_BIT = 6;
    localparam int G0_BIT = 5;
    localparam int R0_BIT = 4;
    localparam int VS_BIT = 3;
    localparam int B1_BIT = 2;
    localparam int G1_BIT = 1;
    localparam int R1_BIT = 0;

    typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} rx_state_t;

    function automatic logic [5:0] pmod_rgb(input logic [7:0] b);
        return {b[R1_BIT], b[R0_BIT], b[G1_BIT], b[G0_BIT], b[B1_BIT], b[B0_BIT]};
    endfunction
endpackage

// File: rtl/vga_crc16_6b.sv
// vga_crc16_6b: CRC-16/CCITT (poly 0x1021) next state for one 6-bit symbol, MSB first.
module vga_crc16_6b (
    input  logic [15:0] crc,
    input  logic [5:0]  data,
    output logic [15:0] crc_next
);
    always_comb begin
        crc_next = crc;
        for (int i = 5; i >= 0; i--)
            crc_next = {crc_next[14:0], 1'b0} ^ ((crc_next[15] ^ data[i]) ? 16'h1021 : 16'h0000);
    end
endmodule

// File: rtl/vga_pmod_receiver.sv
// vga_pmod_receiver: recovers sync timing, pixel coordinates, lock and error count from the PMOD bus.
// Define VGA_RX_CRC_EN to compute a per-frame CRC of the locked pixel stream; otherwise frame_crc is 0.
module vga_pmod_receiver import vga_pkg::*; #(
    parameter int H_TOTAL     = VGA_H_TOTAL,
    parameter int V_TOTAL     = VGA_V_TOTAL,
    parameter int H_START     = VGA_H_SYNC + VGA_H_BACK,
    parameter int V_START     = VGA_V_SYNC + VGA_V_BACK,
    parameter int H_ACTIVE    = VGA_H_ACTIVE,
    parameter int V_ACTIVE    = VGA_V_ACTIVE,
    parameter int LOCK_FRAMES = 2,
    parameter int SYNC_LOW    = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  vga_in,
    output logic        pix_valid,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic [5:0]  pix_rgb,
    output logic        frame_start,
    output logic        locked,
    output logic [7:0]  err_cnt,
    output logic [15:0] frame_crc
);
    localparam logic [9:0] CMAX = 10'd1023;

    logic [7:0] s1, s2;
    logic [9:0] h_cnt, v_cnt;
    logic [3:0] good, good_n;
    logic [7:0] err_cnt_n;
    rx_state_t  state, state_n;
    logic       h_edge, v_edge, line_err, frame_err, err, in_win, ve_q;

    function automatic logic act(input logic b);
        return (SYNC_LOW != 0) ? ~b : b;
    endfunction

    // Sample registers carry no reset so a mid-frame reset does not fake a sync edge
    always_ff @(posedge clk) begin
        s1 <= vga_in;
        s2 <= s1;
    end

    assign h_edge    = act(s1[HS_BIT]) & ~act(s2[HS_BIT]);
    assign v_edge    = act(s1[VS_BIT]) & ~act(s2[VS_BIT]);
    assign line_err  = h_edge ? (h_cnt != 10'(H_TOTAL - 1)) : (h_cnt == CMAX - 10'd1);
    assign frame_err = v_edge ? (v_cnt != 10'(V_TOTAL - 1)) : (h_edge && v_cnt == CMAX - 10'd1);
    assign err       = line_err | frame_err;
    assign in_win    = int'(h_cnt) >= H_START && int'(h_cnt) < H_START + H_ACTIVE &&
                       int'(v_cnt) >= V_START && int'(v_cnt) < V_START + V_ACTIVE;
    assign locked    = state == LOCKED;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h_cnt   <= '0;
            v_cnt   <= '0;
            state   <= SEARCH;
            good    <= '0;
            err_cnt <= '0;
        end else begin
            h_cnt   <= h_edge ? '0 : (h_cnt == CMAX ? h_cnt : h_cnt + 10'd1);
            v_cnt   <= v_edge ? '0 : ((h_edge && v_cnt != CMAX) ? v_cnt + 10'd1 : v_cnt);
            state   <= state_n;
            good    <= good_n;
            err_cnt <= err_cnt_n;
        end
    end

    always_comb begin
        state_n   = state;
        good_n    = good;
        err_cnt_n = err_cnt;
        case (state)
            SEARCH: if (v_edge) begin
                state_n = ACQUIRE;
                good_n  = '0;
            end
            ACQUIRE: if (err) state_n = SEARCH;
                else if (v_edge) begin
                    good_n = good + 4'd1;
                    if (good_n == 4'(LOCK_FRAMES)) state_n = LOCKED;
                end
            LOCKED: if (err) begin
                state_n = SEARCH;
                if (err_cnt != 8'hFF) err_cnt_n = err_cnt + 8'd1;
            end
            default: state_n = SEARCH;
        endcase
    end

    // Output stage: h_cnt/v_cnt describe the sample held in s2
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pix_valid   <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            pix_rgb     <= '0;
            ve_q        <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            pix_valid   <= in_win & locked;
            pix_x       <= h_cnt - 10'(H_START);
            pix_y       <= v_cnt - 10'(V_START);
            pix_rgb     <= pmod_rgb(s2);
            ve_q        <= v_edge;
            frame_start <= ve_q;
        end
    end

`ifdef VGA_RX_CRC_EN
    logic [15:0] crc, crc_nxt;

    vga_crc16_6b u_crc (.crc(crc), .data(pix_rgb), .crc_next(crc_nxt));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            crc       <= 16'hFFFF;
            frame_crc <= '0;
        end else if (err) begin
            crc <= 16'hFFFF;
        end else if (v_edge && locked) begin
            frame_crc <= crc;
            crc       <= 16'hFFFF;
        end else if (pix_valid) begin
            crc <= crc_nxt;
        end
    end
`else
    assign frame_crc = '0;
`endif
endmodule

// File: tb/tb_vga_pmod_receiver.sv
// tb_vga_pmod_receiver: small-timing VGA generator driving the receiver, checked every cycle
// against a behavioural model plus literal checkpoints for lock, error and pixel behaviour.
module tb_vga_pmod_receiver;
    localparam int HT = 24, HS = 6, HA = 12, HSW = 2;
    localparam int VT = 14, VS = 3, VA = 8, VSW = 1;
    localparam int LF = 2;
`ifdef VGA_RX_CRC_EN
    localparam bit CRC_ON = 1;
`else
    localparam bit CRC_ON = 0;
`endif

    logic        clk = 0, rst_n = 0;
    logic [7:0]  vga_in = 8'h88;
    logic        pix_valid, frame_start, locked;
    logic [9:0]  pix_x, pix_y;
    logic [5:0]  pix_rgb;
    logic [7:0]  err_cnt;
    logic [15:0] frame_crc;
    int compared = 0, mismatched = 0, seen_px = 0;

    vga_pmod_receiver #(
        .H_TOTAL(HT), .V_TOTAL(VT), .H_START(HS), .V_START(VS),
        .H_ACTIVE(HA), .V_ACTIVE(VA), .LOCK_FRAMES(LF), .SYNC_LOW(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .vga_in(vga_in), .pix_valid(pix_valid), .pix_x(pix_x),
        .pix_y(pix_y), .pix_rgb(pix_rgb), .frame_start(frame_start), .locked(locked),
        .err_cnt(err_cnt), .frame_crc(frame_crc)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] enc(input bit hs, input bit vs, input logic [5:0] c);
        return {~hs, c[0], c[2], c[4], ~vs, c[1], c[3], c[5]};
    endfunction

    function automatic logic [5:0] dec(input logic [7:0] b);
        return {b[0], b[4], b[1], b[5], b[2], b[6]};
    endfunction

    function automatic logic [5:0] pat(input int x, input int y);
        return (x == 3 && y == 2) ? 6'b110011 : 6'((x * 7 + y * 11 + 1) % 64);
    endfunction

    function automatic int crc6(input int c, input logic [5:0] d);
        int r, fb;
        r = c;
        for (int i = 5; i >= 0; i--) begin
            fb = ((r >> 15) & 1) ^ int'(d[i]);
            r = ((r << 1) & 'hFFFF) ^ (fb != 0 ? 'h1021 : 0);
        end
        return r;
    endfunction

    task automatic tick(input logic [7:0] b);
        @(posedge clk);
        #1 vga_in = b;
    endtask

    task automatic idle(input int n);
        repeat (n) tick(enc(0, 0, 6'd0));
    endtask

    task automatic send_line(input int y, input int len, input bit drop);
        logic [5:0] c;
        for (int x = 0; x < len; x++) begin
            c = (x >= HS && x < HS + HA && y >= VS && y < VS + VA) ? pat(x - HS, y - VS) : 6'd0;
            tick(enc(!drop && x < HSW, y < VSW, c));
        end
    endtask

    task automatic send_frame(input int lines, input int long_line, input int drop_line);
        for (int y = 0; y < lines; y++) send_line(y, y == long_line ? HT + 1 : HT, y == drop_line);
    endtask

    // Model: receiver behaviour expressed in elapsed cycles, line counts and lock progress
    initial begin : cmp
        int hpos, vpos, mode, good, errs, e_x, e_y, run_crc, e_crc;
        bit he, ve, prev_ve, lerr, ferr, err, e_pv, e_fs, r;
        logic [7:0] b0, b1, b2;
        logic [5:0] e_rgb;
        hpos = 0; vpos = 0; mode = 0; good = 0; errs = 0; e_x = 0; e_y = 0;
        run_crc = 'hFFFF; e_crc = 0; prev_ve = 0; e_pv = 0; e_fs = 0; e_rgb = 0;
        b0 = 8'h88; b1 = 8'h88; b2 = 8'h88;
        forever begin
            @(posedge clk);
            r = rst_n;
            b2 = b1; b1 = b0; b0 = vga_in;
            if (!r) begin
                hpos = 0; vpos = 0; mode = 0; good = 0; errs = 0; prev_ve = 0;
                e_pv = 0; e_fs = 0; e_crc = 0; run_crc = 'hFFFF;
            end else begin
                he = !b1[7] && b2[7];
                ve = !b1[3] && b2[3];
                lerr = he ? (hpos + 1 != HT) : (hpos == 1022);
                ferr = ve ? (vpos + 1 != VT) : (he && vpos == 1022);
                err = lerr || ferr;
                if (err) run_crc = 'hFFFF;
                else if (ve && mode == 2) begin
                    e_crc = run_crc;
                    run_crc = 'hFFFF;
                end else if (e_pv) run_crc = crc6(run_crc, e_rgb);
                e_pv = mode == 2 && hpos >= HS && hpos < HS + HA && vpos >= VS && vpos < VS + VA;
                e_x = hpos - HS; e_y = vpos - VS; e_rgb = dec(b2);
                e_fs = prev_ve; prev_ve = ve;
                if (mode == 0 && ve) begin
                    mode = 1; good = 0;
                end else if (mode == 1 && err) mode = 0;
                else if (mode == 1 && ve) begin
                    good++;
                    if (good == LF) mode = 2;
                end else if (mode == 2 && err) begin
                    mode = 0;
                    errs = errs < 255 ? errs + 1 : 255;
                end
                hpos = he ? 0 : (hpos < 1023 ? hpos + 1 : 1023);
                vpos = ve ? 0 : ((he && vpos < 1023) ? vpos + 1 : vpos);
            end
            @(negedge clk);
            check("locked", locked, mode == 2);
            check("err_cnt", err_cnt, errs);
            check("frame_start", frame_start, e_fs);
            check("pix_valid", pix_valid, e_pv);
            check("frame_crc", frame_crc, CRC_ON ? e_crc : 0);
            if (e_pv) begin
                check("pix_x", pix_x, e_x);
                check("pix_y", pix_y, e_y);
                check("pix_rgb", pix_rgb, e_rgb);
            end
            if (pix_valid && pix_x == 10'd3 && pix_y == 10'd2) begin
                seen_px++;
                check("pix_rgb_at_3_2", pix_rgb, 6'b110011);
            end
        end
    end

    initial begin
        idle(5);
        check("rst_pix_valid", pix_valid, 0);
        check("rst_locked", locked, 0);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_frame_start", frame_start, 0);
        check("rst_frame_crc", frame_crc, 0);
        rst_n = 1;
        idle(3);
        // Lock on the third vsync edge
        send_frame(VT, -1, -1);
        send_frame(VT, -1, -1);
        check("locked_before_3rd_vsync", locked, 0);
        send_frame(VT, -1, -1);
        check("locked_after_3rd_vsync", locked, 1);
        check("err_after_lock", err_cnt, 0);
        check("pixel_3_2_seen", seen_px > 0, 1);
        // Dropped hsync while locked, then relock
        send_frame(VT, -1, 5);
        check("locked_after_drop", locked, 0);
        check("err_after_drop", err_cnt, 1);
        send_frame(VT, -1, -1);
        send_frame(VT, -1, -1);
        check("locked_relock_pending", locked, 0);
        send_frame(VT, -1, -1);
        check("locked_relocked", locked, 1);
        check("err_after_relock", err_cnt, 1);
        // Mid-frame reset
        send_frame(7, -1, -1);
        rst_n = 0;
        idle(3);
        rst_n = 1;
        idle(2);
        check("err_after_midreset", err_cnt, 0);
        check("locked_after_midreset", locked, 0);
        // Long line while acquiring
        send_frame(VT, -1, -1);
        send_frame(VT, 3, -1);
        send_frame(VT, -1, -1);
        check("locked_after_long_line", locked, 0);
        check("err_after_long_line", err_cnt, 0);
        send_frame(VT, -1, -1);
        send_frame(VT, -1, -1);
        check("locked_after_reacquire", locked, 1);
        // Hsync held inactive long enough to saturate the line counter
        send_frame(4, -1, -1);
        check("locked_before_hold", locked, 1);
        idle(2000);
        check("err_after_hold", err_cnt, 1);
        check("locked_after_hold", locked, 0);
        send_frame(VT, -1, -1);
        send_frame(VT, -1, -1);
        send_frame(VT, -1, -1);
        check("locked_after_hold_relock", locked, 1);
        check("err_after_hold_relock", err_cnt, 1);
        idle(4);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
